// File: rtl/sram_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port SRAM.
// Data wins by default; a fetch denied STARVE_LIMIT cycles in a row is forced through.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RESP_INST = 2'd1;
  localparam logic [1:0] S_RESP_DATA = 2'd2;
  localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic       r_kill;
  logic       w_starved;
  logic       w_grant_data;
  logic       w_grant_inst;

  // Grants are masked during reset so nothing reaches the SRAM or the ports.
  assign w_starved    = inst_req && (r_starve_cnt == LIMIT);
  assign w_grant_data = !reset && data_req && !w_starved;
  assign w_grant_inst = !reset && inst_req && !w_grant_data;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  assign mem_en    = w_grant_inst || w_grant_data;
  assign mem_addr  = w_grant_data ? data_addr : inst_addr;
  assign mem_wdata = w_grant_data ? data_wdata : 32'h0;
  assign mem_wen   = (w_grant_data && data_wr) ? data_wen : 4'b0000;

  // A flush landing in the response cycle itself must kill that same response.
  assign inst_data_ok = !reset && (r_state == S_RESP_INST) && !r_kill && !flush;
  assign data_data_ok = !reset && (r_state == S_RESP_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_grant_data)      w_state_nxt = S_RESP_DATA;
    else if (w_grant_inst) w_state_nxt = S_RESP_INST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_kill       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_grant_inst && flush;
      if (!inst_req || w_grant_inst)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scenarios followed by random traffic, checked against a
// transaction-level model of grants, starvation and response kills.
module tb_sram_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        inst_req, data_req, data_wr;
  logic [3:0]  data_wen;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_en;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding response kind (0 none, 1 fetch, 2 data),
  // whether that fetch was flushed at grant, and the fetch denial streak.
  int   m_pend   = 0;
  bit   m_killed = 0;
  int   m_streak = 0;
  bit   e_gd, e_gi;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; inst_req = 0; data_req = 0; data_wr = 0; data_wen = 4'h0;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  // Inputs are already driven (after a negedge); check, then clock the model.
  task automatic do_cycle();
    #1;
    e_gd = !reset && data_req && !(inst_req && m_streak >= LIMIT);
    e_gi = !reset && inst_req && !e_gd;
    check("inst_addr_ok", inst_addr_ok, e_gi);
    check("data_addr_ok", data_addr_ok, e_gd);
    check("mem_en", mem_en, e_gi | e_gd);
    check("mem_wen", mem_wen, (e_gd && data_wr) ? data_wen : 4'h0);
    if (e_gd) begin
      check("mem_addr_d", mem_addr, data_addr);
      check("mem_wdata", mem_wdata, data_wdata);
    end
    if (e_gi) check("mem_addr_i", mem_addr, inst_addr);
    check("inst_data_ok", inst_data_ok, !reset && m_pend == 1 && !m_killed && !flush);
    check("data_data_ok", data_data_ok, !reset && m_pend == 2);
    if (inst_data_ok) check("inst_rdata", inst_rdata, mem_rdata);
    if (data_data_ok) check("data_rdata", data_rdata, mem_rdata);
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_killed = 0; m_streak = 0;
    end else begin
      m_pend   = e_gd ? 2 : (e_gi ? 1 : 0);
      m_killed = e_gi && flush;
      if (inst_req && !e_gi) m_streak = (m_streak < LIMIT) ? m_streak + 1 : m_streak;
      else m_streak = 0;
    end
    @(negedge clk);
    mem_rdata = $urandom;
  endtask

  initial begin
    idle_inputs();
    reset = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    inst_req = 1; data_req = 1; data_wr = 1; data_wen = 4'hF;
    #1;
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_wen", mem_wen, 4'h0);
    do_cycle();
    idle_inputs();
    do_cycle();
    reset = 0;

    // Lone fetch from the boot vector.
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    check("boot_addr_ok", inst_addr_ok, 1'b1);
    check("boot_mem_addr", mem_addr, 32'hBFC0_0000);
    do_cycle();
    idle_inputs();
    mem_rdata = 32'hCAFE_0001;
    #1;
    check("boot_data_ok", inst_data_ok, 1'b1);
    check("boot_rdata", inst_rdata, 32'hCAFE_0001);
    do_cycle();

    // Simultaneous fetch and store: store wins.
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_wen = 4'hF;
    data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
    #1;
    check("st_addr_ok", data_addr_ok, 1'b1);
    check("st_inst_blk", inst_addr_ok, 1'b0);
    check("st_wen", mem_wen, 4'hF);
    do_cycle();
    idle_inputs();
    #1;
    check("st_data_ok", data_data_ok, 1'b1);
    do_cycle();

    // Both held: fetch forced through every fifth cycle.
    inst_req = 1; data_req = 1; data_wr = 0; inst_addr = 32'h100; data_addr = 32'h200;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("starve_pat", inst_addr_ok, (i % 5) == 4);
      do_cycle();
    end
    idle_inputs();
    do_cycle();

    // Fetch granted, flushed next cycle alongside a new load.
    inst_req = 1; inst_addr = 32'h300;
    do_cycle();
    idle_inputs();
    flush = 1; data_req = 1; data_addr = 32'h400;
    #1;
    check("flush_kill", inst_data_ok, 1'b0);
    check("flush_dgrant", data_addr_ok, 1'b1);
    do_cycle();
    idle_inputs();
    #1;
    check("flush_dresp", data_data_ok, 1'b1);
    do_cycle();

    // Load granted, then reset lands on its response cycle.
    data_req = 1; data_addr = 32'h500;
    do_cycle();
    idle_inputs();
    reset = 1;
    #1;
    check("rst_drop_ok", data_data_ok, 1'b0);
    do_cycle();
    reset = 0;
    #1;
    check("rst_after_ok", data_data_ok, 1'b0);
    do_cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 5) == 0);
      inst_req   = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      data_wr    = $urandom_range(0, 1);
      data_wen   = 4'($urandom);
      inst_addr  = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
